// File: rtl/tff_chain_seq_if.sv
// Command/status bundle between a command source and the T-stage chain sequencer.
// The master drives the command side; the sequencer (slave) drives chain state and status.
interface tff_chain_seq_if #(
   parameter int STAGES = 4,
   parameter int LEN_W  = 8
);
   logic              start;
   logic [LEN_W-1:0]  len;
   logic              hold;
   logic              clr;
   logic              t_en;
   logic [STAGES-1:0] q;
   logic              busy;
   logic              done;

   modport master (
      output start, len, hold, clr,
      input  t_en, q, busy, done
   );

   modport slave (
      input  start, len, hold, clr,
      output t_en, q, busy, done
   );
endinterface

// File: rtl/tff_chain_seq.sv
// Sequencer for a serial T flip-flop chain: enables the chain for exactly len toggle
// cycles with hold and synchronous clear, then emits a one-cycle done pulse.
module tff_chain_seq #(
   parameter int STAGES = 4,
   parameter int LEN_W  = 8
) (
   input  logic          clk,
   input  logic          rst,
   tff_chain_seq_if.slave ctrl
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t            state_q;
   logic [LEN_W-1:0]  cnt_q;
   logic [STAGES-1:0] q_q;
   logic [STAGES-1:0] q_d;
   logic              busy_q;
   logic              done_q;
   logic              t_en;

   // Stage 0 always toggles; stage i toggles when stage i-1 was high before the edge.
   function automatic logic [STAGES-1:0] chain_next(input logic [STAGES-1:0] cur);
      return cur ^ {cur[STAGES-2:0], 1'b1};
   endfunction

   always_comb begin
      t_en = (state_q == RUN) && !ctrl.hold && !ctrl.clr;
      q_d  = chain_next(q_q);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         q_q     <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else if (ctrl.clr) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         q_q     <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               done_q <= 1'b0;
               if (ctrl.start) begin
                  if (ctrl.len != '0) begin
                     cnt_q   <= ctrl.len;
                     state_q <= RUN;
                     busy_q  <= 1'b1;
                  end else begin
                     state_q <= DONE;
                     done_q  <= 1'b1;
                  end
               end
            end
            RUN: begin
               // hold leaves count, chain and state untouched
               if (t_en) begin
                  q_q   <= q_d;
                  cnt_q <= cnt_q - LEN_W'(1);
                  if (cnt_q == LEN_W'(1)) begin
                     state_q <= DONE;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                  end
               end
            end
            DONE: begin
               state_q <= IDLE;
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign ctrl.t_en = t_en;
   assign ctrl.q    = q_q;
   assign ctrl.busy = busy_q;
   assign ctrl.done = done_q;

endmodule

// File: tb/tb_tff_chain_seq.sv
// Bench for tff_chain_seq: directed scenarios plus random commands, checked against a
// cycle model built from remaining-toggle counting and per-bit chain arithmetic.
module tb_tff_chain_seq;
   localparam int STAGES = 4;
   localparam int LEN_W  = 8;

   logic clk;
   logic rst;
   int   n_cmp;
   int   n_err;

   // reference model state
   logic [STAGES-1:0] m_q;
   int                m_rem;
   bit                m_done;

   tff_chain_seq_if #(.STAGES(STAGES), .LEN_W(LEN_W)) bus ();

   tff_chain_seq #(.STAGES(STAGES), .LEN_W(LEN_W)) dut (
      .clk  (clk),
      .rst  (rst),
      .ctrl (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [STAGES-1:0] model_toggle(input logic [STAGES-1:0] cur);
      logic [STAGES-1:0] nxt;
      nxt[0] = ~cur[0];
      for (int i = 1; i < STAGES; i++)
         nxt[i] = cur[i-1] ? ~cur[i] : cur[i];
      return nxt;
   endfunction

   task automatic model_reset();
      m_q    = '0;
      m_rem  = 0;
      m_done = 1'b0;
   endtask

   // Inputs are applied at a falling edge; t_en is checked before the rising edge,
   // registered outputs at the following falling edge.
   task automatic step(input bit s, input logic [LEN_W-1:0] l, input bit h, input bit c);
      bus.start = s;
      bus.len   = l;
      bus.hold  = h;
      bus.clr   = c;
      #1;
      chk("t_en", 32'(bus.t_en), 32'((m_rem > 0) && !h && !c));
      if (c) begin
         model_reset();
      end else if (m_done) begin
         m_done = 1'b0;
      end else if (m_rem > 0) begin
         if (!h) begin
            m_q   = model_toggle(m_q);
            m_rem = m_rem - 1;
            if (m_rem == 0) m_done = 1'b1;
         end
      end else if (s) begin
         if (l == 0) m_done = 1'b1;
         else        m_rem  = int'(l);
      end
      @(negedge clk);
      chk("q",    32'(bus.q),    32'(m_q));
      chk("busy", 32'(bus.busy), 32'(m_rem > 0));
      chk("done", 32'(bus.done), 32'(m_done));
      chk("busy_done_excl", 32'(bus.busy && bus.done), 32'd0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0);
   endtask

   initial begin
      int busy_cycles;
      int lim;
      n_cmp = 0;
      n_err = 0;
      model_reset();
      rst       = 1'b0;
      bus.start = 1'b0;
      bus.len   = '0;
      bus.hold  = 1'b0;
      bus.clr   = 1'b0;
      #3;
      chk("rst_q",    32'(bus.q),    32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_done", 32'(bus.done), 32'd0);
      chk("rst_t_en", 32'(bus.t_en), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;

      // len=4 from zero: 0001 0010 0111 1000, then a single done
      step(1'b1, 8'd4, 1'b0, 1'b0);
      chk("l4_busy_e0", 32'(bus.busy), 32'd1);
      idle(1); chk("l4_q1", 32'(bus.q), 32'h1);
      idle(1); chk("l4_q2", 32'(bus.q), 32'h2);
      idle(1); chk("l4_q3", 32'(bus.q), 32'h7);
      chk("l4_busy_last", 32'(bus.busy), 32'd1);
      idle(1); chk("l4_q4", 32'(bus.q), 32'h8);
      chk("l4_done", 32'(bus.done), 32'd1);
      idle(1); chk("l4_done_fall", 32'(bus.done), 32'd0);
      chk("l4_q_hold", 32'(bus.q), 32'h8);

      // back-to-back single toggle right after done
      step(1'b1, 8'd1, 1'b0, 1'b0);
      idle(1); chk("b2b_q", 32'(bus.q), 32'h9);
      chk("b2b_done", 32'(bus.done), 32'd1);
      idle(1);

      // clear, then len=3 with two hold cycles after the first toggle
      step(1'b0, '0, 1'b0, 1'b1);
      chk("clr_q", 32'(bus.q), 32'h0);
      busy_cycles = 0;
      step(1'b1, 8'd3, 1'b0, 1'b0); busy_cycles += int'(bus.busy);
      step(1'b0, '0, 1'b0, 1'b0);   busy_cycles += int'(bus.busy);
      step(1'b0, '0, 1'b1, 1'b0);   busy_cycles += int'(bus.busy);
      step(1'b0, '0, 1'b1, 1'b0);   busy_cycles += int'(bus.busy);
      step(1'b0, '0, 1'b0, 1'b0);   busy_cycles += int'(bus.busy);
      chk("hold_done_early", 32'(bus.done), 32'd0);
      step(1'b0, '0, 1'b0, 1'b0);   busy_cycles += int'(bus.busy);
      chk("hold_busy_cycles", 32'(busy_cycles), 32'd5);
      chk("hold_q_end", 32'(bus.q), 32'h7);
      chk("hold_done", 32'(bus.done), 32'd1);
      idle(1);

      // len=0: immediate done, chain untouched
      step(1'b1, 8'd0, 1'b0, 1'b0);
      chk("len0_done", 32'(bus.done), 32'd1);
      chk("len0_q", 32'(bus.q), 32'h7);
      idle(2);

      // restart during RUN is ignored
      step(1'b1, 8'd3, 1'b0, 1'b0);
      busy_cycles = 1;
      step(1'b1, 8'd6, 1'b0, 1'b0); busy_cycles += int'(bus.busy);
      step(1'b1, 8'd6, 1'b0, 1'b0); busy_cycles += int'(bus.busy);
      step(1'b0, '0, 1'b0, 1'b0);   busy_cycles += int'(bus.busy);
      chk("restart_busy_cycles", 32'(busy_cycles), 32'd3);
      idle(3);

      // clear mid-RUN
      step(1'b1, 8'd5, 1'b0, 1'b0);
      idle(2);
      step(1'b0, '0, 1'b0, 1'b1);
      chk("clrmid_q", 32'(bus.q), 32'h0);
      chk("clrmid_busy", 32'(bus.busy), 32'd0);
      idle(4);

      // asynchronous reset mid-RUN
      step(1'b1, 8'd6, 1'b0, 1'b0);
      idle(2);
      #2 rst = 1'b0;
      #1;
      model_reset();
      chk("arst_q",    32'(bus.q),    32'd0);
      chk("arst_busy", 32'(bus.busy), 32'd0);
      chk("arst_t_en", 32'(bus.t_en), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      idle(6);

      // clear coinciding with the final enabled edge
      step(1'b1, 8'd2, 1'b0, 1'b0);
      idle(1);
      step(1'b0, '0, 1'b0, 1'b1);
      chk("clrfinal_q", 32'(bus.q), 32'h0);
      chk("clrfinal_done", 32'(bus.done), 32'd0);
      idle(2);

      // maximum length: exactly 255 toggle cycles, no wrap
      step(1'b1, 8'd255, 1'b0, 1'b0);
      busy_cycles = int'(bus.busy);
      lim = 0;
      while (bus.busy && lim < 400) begin
         idle(1);
         busy_cycles += int'(bus.busy);
         lim++;
      end
      chk("max_busy_cycles", 32'(busy_cycles), 32'd255);
      chk("max_done", 32'(bus.done), 32'd1);
      idle(1);

      // random commands
      for (int i = 0; i < 600; i++) begin
         step(($urandom_range(0, 3) == 0),
              LEN_W'($urandom_range(0, 7)),
              ($urandom_range(0, 4) == 0),
              ($urandom_range(0, 40) == 0));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end
endmodule
